// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: init ownership, then refresh > write > read grants with a NOP gap.
// Define SDRAM_ARBIT_RR_EN for round-robin write/read tie-breaking (default: write wins).
module sdram_arbit (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_bank,
    input  logic [12:0] init_addr,
    input  logic        init_end,
    input  logic        aref_req,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_bank,
    input  logic [12:0] aref_addr,
    input  logic        aref_end,
    input  logic        wr_req,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_bank,
    input  logic [12:0] wr_addr,
    input  logic        wr_end,
    input  logic        wr_sdram_en,
    input  logic [15:0] wr_sdram_data,
    input  logic        rd_req,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_bank,
    input  logic [12:0] rd_addr,
    input  logic        rd_end,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic [15:0] rd_sdram_data,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    inout  wire  [15:0] sdram_dq
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   wr_wins;
    logic   dq_oe;
    logic [3:0] cmd_mux;

`ifdef SDRAM_ARBIT_RR_EN
    // 1 = read was granted last, so write takes the next tie.
    logic last_rd_q, last_rd_d;

    assign wr_wins = wr_req && (!rd_req || last_rd_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) last_rd_q <= 1'b1;
        else       last_rd_q <= last_rd_d;
    end

    always_comb begin
        last_rd_d = last_rd_q;
        if (state_q == ST_ARBIT && state_d == ST_WRITE) last_rd_d = 1'b0;
        if (state_q == ST_ARBIT && state_d == ST_READ)  last_rd_d = 1'b1;
    end
`else
    assign wr_wins = wr_req;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (init_end) state_d = ST_ARBIT;
            ST_ARBIT: begin
                if (aref_req)     state_d = ST_AREF;
                else if (wr_wins) state_d = ST_WRITE;
                else if (rd_req)  state_d = ST_READ;
            end
            ST_AREF:  if (aref_end) state_d = ST_ARBIT;
            ST_WRITE: if (wr_end)   state_d = ST_ARBIT;
            ST_READ:  if (rd_end)   state_d = ST_ARBIT;
            default:  state_d = ST_INIT;
        endcase
    end

    // Grants decode the state register only, so no request-to-grant combinational path.
    assign aref_en = (state_q == ST_AREF);
    assign wr_en   = (state_q == ST_WRITE);
    assign rd_en   = (state_q == ST_READ);

    always_comb begin
        cmd_mux    = 4'b0111;
        sdram_ba   = 2'b11;
        sdram_addr = 13'h1FFF;
        case (state_q)
            ST_INIT: begin
                cmd_mux    = init_cmd;
                sdram_ba   = init_bank;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                cmd_mux    = aref_cmd;
                sdram_ba   = aref_bank;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                cmd_mux    = wr_cmd;
                sdram_ba   = wr_bank;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                cmd_mux    = rd_cmd;
                sdram_ba   = rd_bank;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;
    assign sdram_cke = 1'b1;

    assign dq_oe         = (state_q == ST_WRITE) && wr_sdram_en;
    assign sdram_dq      = dq_oe ? wr_sdram_data : 16'hzzzz;
    assign rd_sdram_data = sdram_dq;

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Command-bus arbiter for the SDRAM controller. It holds the bus for `sdram_init` until `init_end`, then grants the single SDRAM command, bank and address bus to one of three requesters: auto-refresh, write or read. It owns the tri-state `sdram_dq` pins. It sits between the init/aref/write/read sub-modules and the SDRAM device pins.

## Interface
- No parameters. Widths are fixed for W9825G6KH: bank 2, address 13, data 16.
- `clk`  in  1  100 MHz controller clock; all logic is on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `init_cmd`/`init_bank`/`init_addr`  in  4/2/13  init-module bus. Command encoding is {cs_n, ras_n, cas_n, we_n}.
- `init_end`  in  1  initialization complete; level.
- `aref_req`  in  1  refresh request; level, held until granted.
- `aref_cmd`/`aref_bank`/`aref_addr`  in  4/2/13  refresh-module bus.
- `aref_end`  in  1  one-cycle pulse; refresh sequence done.
- `wr_req`  in  1  write request; level.
- `wr_cmd`/`wr_bank`/`wr_addr`  in  4/2/13  write-module bus.
- `wr_end`  in  1  one-cycle pulse; write burst done.
- `wr_sdram_en`  in  1  drive `sdram_dq` this cycle.
- `wr_sdram_data`  in  16  write data.
- `rd_req`  in  1  read request; level.
- `rd_cmd`/`rd_bank`/`rd_addr`  in  4/2/13  read-module bus.
- `rd_end`  in  1  one-cycle pulse; read burst done.
- `aref_en`/`wr_en`/`rd_en`  out  1 each  grant level to each requester.
- `rd_sdram_data`  out  16  mirrors `sdram_dq` combinationally.
- `sdram_cke`  out  1  constant 1.
- `sdram_cs_n`/`sdram_ras_n`/`sdram_cas_n`/`sdram_we_n`  out  1 each  muxed command bits.
- `sdram_ba`  out  2  muxed bank.
- `sdram_addr`  out  13  muxed address.
- `sdram_dq`  inout  16  SDRAM data bus.

## Operation
- States: INIT, ARBIT, AREF, WRITE, READ. The state is a register and resets to INIT.
- INIT → ARBIT when `init_end`=1 is sampled. Otherwise stay in INIT.
- In ARBIT, sample the requests with priority `aref_req` > `wr_req` > `rd_req`, and go to AREF, WRITE or READ accordingly. With no request, stay in ARBIT.
- AREF → ARBIT on `aref_end`. WRITE → ARBIT on `wr_end`. READ → ARBIT on `rd_end`.
- Every grant passes through at least one ARBIT cycle. Back-to-back grants are therefore separated by one NOP cycle.
- Grant levels:
  - `aref_en` = (state==AREF).
  - `wr_en` = (state==WRITE).
  - `rd_en` = (state==READ).
  - All are registered, with no combinational path from the request inputs.
- Bus mux, combinational on the registered state:
  - INIT selects `init_*`.
  - AREF selects `aref_*`.
  - WRITE selects `wr_*`.
  - READ selects `rd_*`.
  - ARBIT drives NOP 4'b0111, `sdram_ba`=2'b11 and `sdram_addr`=13'h1FFF.
- `sdram_dq` = `wr_sdram_data` when `wr_sdram_en`=1, else high-Z. `wr_sdram_en` is honoured only in WRITE and forced to high-Z in every other state.
- Requests and `*_end` pulses from non-granted requesters are ignored. `init_end` is ignored after leaving INIT.

## Timing
- Reset values:
  - state INIT.
  - `aref_en`/`wr_en`/`rd_en` = 0.
  - `sdram_cke` = 1.
  - Bus outputs follow the `init_*` inputs.
  - `sdram_dq` is high-Z.
- Grant latency: the request is sampled in ARBIT at edge N, and `*_en` is high and the bus switched after edge N. This is 1 cycle from the ARBIT sample.
- Release: `*_end` is sampled at edge M, and `*_en` is low and the bus at NOP after edge M.
- `*_end` and a new request in the same cycle: the state goes to ARBIT. The new request is granted one cycle later.
- `aref_req` and `wr_req` both high in ARBIT: AREF is granted. `wr_req` must remain held; it is granted after `aref_end`.
- Asserting `rstn` low mid-grant immediately returns to INIT and drops all `*_en`. The granted sub-module must be reset by the same `rstn`.

## Configuration
- `SDRAM_ARBIT_RR_EN` defined:
  - Write/read priority is round-robin.
  - A 1-bit last-grant register resets to "read", so write wins the first tie.
  - On a tie in ARBIT, the side not granted last wins.
  - Refresh always keeps top priority.
- `SDRAM_ARBIT_RR_EN` not defined: write has fixed priority over read, and no last-grant register exists.

## Test plan
- **Init:** hold `init_end`=0 for 20 cycles with `aref_req`=1. Required: `sdram_cs_n..we_n` equal `init_cmd` and `aref_en`=0. Then `init_end`=1: ARBIT NOP for one cycle, then `aref_en`=1 on the next cycle.
- **Priority:** in ARBIT, `aref_req`=`wr_req`=`rd_req`=1. Required grant order is AREF, WRITE, READ. Each grant is separated by exactly one NOP cycle with `sdram_ba`=2'b11 and `sdram_addr`=13'h1FFF.
- **DQ drive:** in WRITE with `wr_sdram_en`=1 and `wr_sdram_data`=16'hA5A5, `sdram_dq`=16'hA5A5. With `wr_sdram_en`=1 in READ, `sdram_dq` is high-Z and `rd_sdram_data` follows the model's data.
- **Round-robin:** `wr_req` and `rd_req` held high for 4 grants. With `SDRAM_ARBIT_RR_EN` defined, the order is W, R, W, R. Without it, the order is W, W, W, W.
- **Reset mid-grant:** pulse `rstn`=0 during WRITE. Required: `wr_en`=0 asynchronously, the state is INIT, and `sdram_dq` is high-Z.
- **Stray end:** `rd_end` pulse while in WRITE. Required: the state remains WRITE and `wr_en` stays 1.
